// File: rtl/accum_tile_scheduler.sv
// rtl/accum_tile_scheduler.sv - ping-pong output accumulator sequencer for one job of output tiles
//
// Steers cfg_ktiles partial-sum tiles from the PE array into one accumulator
// buffer per output tile, offers each full buffer to the output writer and
// recycles it once the writer reports drain_done. Buffers are used round-robin.
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   cfg_valid/cfg_ready     job descriptor handshake (ready only while idle)
//   cfg_ktiles, cfg_ntiles  k-tiles per output tile (0 means 1), output tiles per job
//   ps_valid/ps_ready       partial-sum tile handshake from the PE array
//   acc_en, acc_clear       accumulate strobe; clear marks the first k-tile (overwrite)
//   acc_buf                 buffer targeted by acc_en
//   wb_valid/wb_ready       writeback request/accept for buffer wb_buf
//   wb_buf                  buffer offered for writeback
//   drain_done              pulse: oldest draining buffer has been read out
//   busy                    a job is in progress
//   done                    one-cycle pulse when the job is finished and drained
//   err                     sticky: drain_done with nothing draining; cleared on job accept

module accum_tile_scheduler #(
  parameter int NBUF  = 2,
  parameter int BUF_W = $clog2(NBUF),
  parameter int KT_W  = 8,
  parameter int NT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [KT_W-1:0]  cfg_ktiles,
  input  logic [NT_W-1:0]  cfg_ntiles,
  input  logic             ps_valid,
  output logic             ps_ready,
  output logic             acc_en,
  output logic             acc_clear,
  output logic [BUF_W-1:0] acc_buf,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [BUF_W-1:0] wb_buf,
  input  logic             drain_done,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_WAIT_BUF, S_FLUSH} state_t;
  typedef enum logic [1:0] {B_FREE, B_FILLING, B_FULL, B_DRAINING} bstate_t;

  state_t           state, state_n;
  bstate_t          buf_st   [NBUF];
  bstate_t          buf_st_n [NBUF];
  logic [BUF_W-1:0] fill_ptr, fill_ptr_n, wb_ptr, wb_ptr_n, drain_ptr, drain_ptr_n;
  logic [BUF_W-1:0] fill_nxt;
  logic [KT_W-1:0]  k_cnt, k_cnt_n, ktiles_q, ktiles_n;
  logic [NT_W-1:0]  tile_cnt, tile_cnt_n, ntiles_q, ntiles_n, tile_inc;
  logic             err_n;
  logic             all_free;
  logic             last_k;
  logic             wb_fire;

  // NBUF is a power of two, so pointer increments wrap naturally.
  assign fill_nxt = fill_ptr + 1'b1;
  assign tile_inc = tile_cnt + 1'b1;
  assign last_k   = (k_cnt == ktiles_q - 1'b1);

  assign cfg_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign ps_ready  = (state == S_ACCUM);
  assign acc_en    = ps_valid & ps_ready;
  assign acc_clear = acc_en & (k_cnt == '0);
  assign acc_buf   = fill_ptr;
  // Decoded purely from flops: stays stable until the writer accepts, because
  // wb_ptr and the FULL state only change on the handshake itself.
  assign wb_valid  = (state != S_IDLE) && (buf_st[wb_ptr] == B_FULL);
  assign wb_buf    = wb_ptr;
  assign wb_fire   = wb_valid & wb_ready;
  assign done      = (state == S_FLUSH) && all_free;

  always_comb begin
    all_free = 1'b1;
    for (int i = 0; i < NBUF; i++) begin
      if (buf_st[i] != B_FREE) all_free = 1'b0;
    end
  end

  always_comb begin
    state_n     = state;
    fill_ptr_n  = fill_ptr;
    wb_ptr_n    = wb_ptr;
    drain_ptr_n = drain_ptr;
    k_cnt_n     = k_cnt;
    tile_cnt_n  = tile_cnt;
    ktiles_n    = ktiles_q;
    ntiles_n    = ntiles_q;
    err_n       = err;
    for (int i = 0; i < NBUF; i++) buf_st_n[i] = buf_st[i];

    case (state)
      S_IDLE: begin
        if (cfg_valid) begin
          ktiles_n    = (cfg_ktiles == '0) ? KT_W'(1) : cfg_ktiles;
          ntiles_n    = cfg_ntiles;
          err_n       = 1'b0;
          fill_ptr_n  = '0;
          wb_ptr_n    = '0;
          drain_ptr_n = '0;
          k_cnt_n     = '0;
          tile_cnt_n  = '0;
          if (cfg_ntiles == '0) begin
            state_n = S_FLUSH;
          end else begin
            buf_st_n[0] = B_FILLING;
            state_n     = S_ACCUM;
          end
        end
      end
      S_ACCUM: begin
        if (acc_en) begin
          if (last_k) begin
            buf_st_n[fill_ptr] = B_FULL;
            k_cnt_n            = '0;
            tile_cnt_n         = tile_inc;
            fill_ptr_n         = fill_nxt;
            if (tile_inc == ntiles_q) begin
              state_n = S_FLUSH;
            end else if (buf_st[fill_nxt] == B_FREE) begin
              // Claim the next buffer on the same edge so the PE stream sees no bubble.
              buf_st_n[fill_nxt] = B_FILLING;
            end else begin
              state_n = S_WAIT_BUF;
            end
          end else begin
            k_cnt_n = k_cnt + 1'b1;
          end
        end
      end
      S_WAIT_BUF: begin
        // fill_ptr already points at the wanted buffer; only its registered state counts.
        if (buf_st[fill_ptr] == B_FREE) begin
          buf_st_n[fill_ptr] = B_FILLING;
          state_n            = S_ACCUM;
        end
      end
      S_FLUSH: begin
        if (all_free) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // The filling, full and draining buffers are always distinct, so these
    // updates never target the same entry as the fill-side updates above.
    if (wb_fire) begin
      buf_st_n[wb_ptr] = B_DRAINING;
      wb_ptr_n         = wb_ptr + 1'b1;
    end

    if (drain_done) begin
      if (buf_st[drain_ptr] == B_DRAINING) begin
        buf_st_n[drain_ptr] = B_FREE;
        drain_ptr_n         = drain_ptr + 1'b1;
      end else begin
        err_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      fill_ptr  <= '0;
      wb_ptr    <= '0;
      drain_ptr <= '0;
      k_cnt     <= '0;
      tile_cnt  <= '0;
      ktiles_q  <= '0;
      ntiles_q  <= '0;
      err       <= 1'b0;
      for (int i = 0; i < NBUF; i++) buf_st[i] <= B_FREE;
    end else begin
      state     <= state_n;
      fill_ptr  <= fill_ptr_n;
      wb_ptr    <= wb_ptr_n;
      drain_ptr <= drain_ptr_n;
      k_cnt     <= k_cnt_n;
      tile_cnt  <= tile_cnt_n;
      ktiles_q  <= ktiles_n;
      ntiles_q  <= ntiles_n;
      err       <= err_n;
      for (int i = 0; i < NBUF; i++) buf_st[i] <= buf_st_n[i];
    end
  end

endmodule

// File: tb/tb_accum_tile_scheduler.sv
// tb/tb_accum_tile_scheduler.sv - directed bench for accum_tile_scheduler

module tb_accum_tile_scheduler;

  logic        clk;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_ktiles;
  logic [15:0] cfg_ntiles;
  logic        ps_valid;
  logic        ps_ready;
  logic        acc_en;
  logic        acc_clear;
  logic [0:0]  acc_buf;
  logic        wb_valid;
  logic        wb_ready;
  logic [0:0]  wb_buf;
  logic        drain_done;
  logic        busy;
  logic        done;
  logic        err;

  accum_tile_scheduler #(.NBUF(2), .BUF_W(1), .KT_W(8), .NT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ktiles(cfg_ktiles), .cfg_ntiles(cfg_ntiles),
    .ps_valid(ps_valid), .ps_ready(ps_ready),
    .acc_en(acc_en), .acc_clear(acc_clear), .acc_buf(acc_buf),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_buf(wb_buf),
    .drain_done(drain_done), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec  = 0;
  int nfail = 0;
  int cyc   = 0;
  int drain_dly = 0;
  int acc_bufs[$];
  int acc_clrs[$];
  int wb_bufs[$];
  int drain_q[$];
  int done_cnt, done_cyc, last_drain_cyc, wb_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    acc_bufs.delete();
    acc_clrs.delete();
    wb_bufs.delete();
    drain_q.delete();
    done_cnt = 0;
    done_cyc = -1;
    last_drain_cyc = -1;
    wb_seen = 0;
  endtask

  // Called just after a negedge with inputs already set for this cycle:
  // sample what the coming posedge will see, then move to the next negedge.
  task automatic cycle();
    #1;
    if (acc_en) begin
      acc_bufs.push_back(int'(acc_buf));
      acc_clrs.push_back(int'(acc_clear));
    end
    if (wb_valid) wb_seen = 1;
    if (wb_valid && wb_ready) begin
      wb_bufs.push_back(int'(wb_buf));
      if (drain_dly > 0) drain_q.push_back(cyc + drain_dly);
    end
    if (drain_done) last_drain_cyc = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      drain_done = 1'b0;
      if (drain_q.size() > 0 && drain_q[0] == cyc) begin
        drain_done = 1'b1;
        void'(drain_q.pop_front());
      end
      cycle();
    end
    drain_done = 1'b0;
  endtask

  task automatic start_job(input int k, input int n);
    cfg_valid  = 1'b1;
    cfg_ktiles = 8'(k);
    cfg_ntiles = 16'(n);
    #1;
    chk("cfg_ready before accept", cfg_ready, 1);
    @(negedge clk);
    cyc++;
    cfg_valid = 1'b0;
  endtask

  int exp_b1[6] = '{0, 0, 0, 1, 1, 1};
  int exp_c1[6] = '{1, 0, 0, 1, 0, 0};
  int exp_b6[4] = '{0, 0, 1, 1};
  int c0;

  initial begin
    rst_n = 1'b0;
    cfg_valid = 1'b0; cfg_ktiles = '0; cfg_ntiles = '0;
    ps_valid = 1'b0; wb_ready = 1'b0; drain_done = 1'b0;
    clr();
    repeat (3) @(negedge clk);
    #1;
    chk("rst cfg_ready", cfg_ready, 1);
    chk("rst ps_ready", ps_ready, 0);
    chk("rst wb_valid", wb_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    chk("rst acc_en", acc_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic two-tile job with three k-tiles each.
    start_job(3, 2);
    ps_valid = 1'b1; wb_ready = 1'b1; drain_dly = 4;
    clr();
    run(20);
    chk("t1 acc count", acc_bufs.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < acc_bufs.size()) begin
        chk($sformatf("t1 acc_buf[%0d]", i), acc_bufs[i], exp_b1[i]);
        chk($sformatf("t1 acc_clear[%0d]", i), acc_clrs[i], exp_c1[i]);
      end
    end
    chk("t1 wb count", wb_bufs.size(), 2);
    if (wb_bufs.size() == 2) begin
      chk("t1 wb_buf[0]", wb_bufs[0], 0);
      chk("t1 wb_buf[1]", wb_bufs[1], 1);
    end
    chk("t1 done count", done_cnt, 1);
    chk("t1 done after last drain", done_cyc, last_drain_cyc + 1);
    chk("t1 idle after", cfg_ready, 1);

    // Both buffers fill while the writer stalls, then the stream waits.
    start_job(1, 4);
    ps_valid = 1'b1; wb_ready = 1'b0; drain_dly = 0;
    clr();
    run(5);
    chk("t2 acc count", acc_bufs.size(), 2);
    if (acc_bufs.size() == 2) begin
      chk("t2 acc_buf[0]", acc_bufs[0], 0);
      chk("t2 acc_buf[1]", acc_bufs[1], 1);
    end
    #1;
    chk("t2 ps_ready stalled", ps_ready, 0);
    chk("t2 wb_valid held", wb_valid, 1);
    chk("t2 wb_buf held", wb_buf, 0);
    wb_ready = 1'b1;
    cycle();
    wb_ready = 1'b0;
    drain_done = 1'b1;
    cycle();
    drain_done = 1'b0;
    acc_bufs.delete();
    acc_clrs.delete();
    run(3);
    chk("t2 resume acc count", acc_bufs.size(), 1);
    if (acc_bufs.size() == 1) begin
      chk("t2 third acc_buf", acc_bufs[0], 0);
      chk("t2 third acc_clear", acc_clrs[0], 1);
    end
    wb_ready = 1'b1; drain_dly = 2;
    run(40);
    chk("t2 done count", done_cnt, 1);
    chk("t2 err", err, 0);

    // ktiles of zero behaves as one.
    start_job(0, 1);
    ps_valid = 1'b1; wb_ready = 1'b1; drain_dly = 3;
    clr();
    run(15);
    chk("t3 acc count", acc_bufs.size(), 1);
    if (acc_bufs.size() == 1) chk("t3 acc_clear", acc_clrs[0], 1);
    chk("t3 done count", done_cnt, 1);

    // Empty job finishes immediately.
    start_job(5, 0);
    clr();
    c0 = cyc;
    run(4);
    chk("t3 ntiles0 done cycle", done_cyc, c0);
    chk("t3 ntiles0 done count", done_cnt, 1);
    chk("t3 ntiles0 acc count", acc_bufs.size(), 0);
    chk("t3 ntiles0 wb_valid seen", wb_seen, 0);

    // Stray drain_done while idle.
    ps_valid = 1'b0;
    drain_done = 1'b1;
    cycle();
    drain_done = 1'b0;
    #1;
    chk("t4 err set", err, 1);
    chk("t4 still idle", cfg_ready, 1);
    chk("t4 busy", busy, 0);
    start_job(1, 1);
    #1;
    chk("t4 err cleared", err, 0);
    ps_valid = 1'b1; wb_ready = 1'b1; drain_dly = 2;
    clr();
    run(15);
    chk("t4 done count", done_cnt, 1);

    // Asynchronous reset in the middle of a tile.
    start_job(4, 2);
    ps_valid = 1'b1; wb_ready = 1'b1; drain_dly = 2;
    clr();
    run(2);
    chk("t5 pre-reset acc count", acc_bufs.size(), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5 rst ps_ready", ps_ready, 0);
    chk("t5 rst wb_valid", wb_valid, 0);
    chk("t5 rst busy", busy, 0);
    chk("t5 rst done", done, 0);
    chk("t5 rst cfg_ready", cfg_ready, 1);
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
    @(negedge clk);
    cyc++;
    start_job(2, 1);
    clr();
    run(1);
    chk("t5 restart acc count", acc_bufs.size(), 1);
    if (acc_bufs.size() == 1) begin
      chk("t5 restart acc_buf", acc_bufs[0], 0);
      chk("t5 restart acc_clear", acc_clrs[0], 1);
    end
    run(15);
    chk("t5 done count", done_cnt, 1);

    // Descriptor offered while busy is ignored.
    start_job(2, 2);
    ps_valid = 1'b1; wb_ready = 1'b1; drain_dly = 3;
    clr();
    run(1);
    cfg_valid = 1'b1; cfg_ktiles = 8'd1; cfg_ntiles = 16'd9;
    #1;
    chk("t6 cfg_ready busy", cfg_ready, 0);
    cycle();
    cfg_valid = 1'b0;
    run(20);
    chk("t6 acc count", acc_bufs.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < acc_bufs.size()) chk($sformatf("t6 acc_buf[%0d]", i), acc_bufs[i], exp_b6[i]);
    end
    chk("t6 done count", done_cnt, 1);
    chk("t6 idle after", cfg_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
